// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
// Imported by the interface, the per-channel slot and the top level.
package stream_demux_pkg;

  localparam int N_OUT = 4;

  typedef logic [1:0] chan_sel_t;
  typedef logic [1:0] level_t;

  // One-hot destination mask for a select value.
  function automatic logic [N_OUT-1:0] sel_decode(input chan_sel_t sel);
    return N_OUT'(1) << sel;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side stream plus four consumer-side streams of the demultiplexer.
// The master modport is the environment; the slave modport is the demux.
interface stream_demux_if #(
  parameter int WIDTH = 4
);
  import stream_demux_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_data;
  chan_sel_t                    in_sel;
  logic [N_OUT-1:0]             out_valid;
  logic [N_OUT-1:0]             out_ready;
  logic [N_OUT-1:0][WIDTH-1:0]  out_data;
  level_t [N_OUT-1:0]           out_level;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_level
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_level
  );

endinterface

// File: rtl/stream_demux_slot.sv
// One 2-entry in-order buffer for a single output channel.
// The head word is always presented; when empty it holds the last value.
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output level_t           level
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  level_t           level_q, level_d;
  logic             do_push;
  logic             do_pop;

  // NOTE: defaults come first so every path assigns every _d signal; no latches.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    do_push = push && (level_q != level_t'(DEPTH));
    do_pop  = pop_ready && (level_q != '0);

    case ({do_push, do_pop})
      2'b10: begin
        level_d = level_t'(level_q + 2'd1);
        if (level_q == '0) head_d = push_data;
        else               tail_d = push_data;
      end
      2'b01: begin
        level_d = level_t'(level_q - 2'd1);
        if (level_q == level_t'(DEPTH)) head_d = tail_q;
      end
      // Push and pop together only happen at level 1: the new word becomes head.
      2'b11: head_d = push_data;
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared as well, so out_data reads 0 after reset.
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  assign valid = (level_q != '0);
  assign head  = head_q;
  assign level = level_q;

endmodule

// File: rtl/stream_demux_1_4.sv
// 1-to-4 stream demultiplexer: routes each accepted word to the buffer of its
// selected channel. Acceptance never depends on out_ready.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_demux_if.slave  bus
);

  logic [N_OUT-1:0] push;
  level_t [N_OUT-1:0] level;
  logic             in_ready;

  always_comb begin
    in_ready = rst_n && (level[bus.in_sel] != level_t'(DEPTH));
    push     = (bus.in_valid && in_ready) ? sel_decode(bus.in_sel) : '0;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_level = level;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    stream_demux_slot #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[k]),
      .push_data (bus.in_data),
      .pop_ready (bus.out_ready[k]),
      .valid     (bus.out_valid[k]),
      .head      (bus.out_data[k]),
      .level     (level[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: per-channel expected-word queues
// filled on accept and compared against head/level/valid every cycle.
module tb_stream_demux_1_4;
  import stream_demux_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   mon_en;
  int   pop_cnt [N_OUT];
  logic [W-1:0] exp_q [N_OUT][$];

  stream_demux_if #(.WIDTH(W)) bus ();

  stream_demux_1_4 #(.WIDTH(W), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: compare DUT state to the model, then apply this cycle's handshakes.
  task automatic sb_sample();
    logic exp_rdy;
    for (int k = 0; k < N_OUT; k++) begin
      checks++;
      if (bus.out_level[k] !== level_t'(exp_q[k].size())) begin
        errors++;
        $display("FAIL sb_level ch%0d got %0d exp %0d", k, bus.out_level[k], exp_q[k].size());
      end
      checks++;
      if (bus.out_valid[k] !== (exp_q[k].size() != 0)) begin
        errors++;
        $display("FAIL sb_valid ch%0d got %b exp %b", k, bus.out_valid[k], exp_q[k].size() != 0);
      end
      if (exp_q[k].size() != 0) begin
        checks++;
        if (bus.out_data[k] !== exp_q[k][0]) begin
          errors++;
          $display("FAIL sb_head ch%0d got %h exp %h", k, bus.out_data[k], exp_q[k][0]);
        end
      end
    end
    exp_rdy = rst_n && (exp_q[bus.in_sel].size() != 2);
    checks++;
    if (bus.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL sb_in_ready got %b exp %b", bus.in_ready, exp_rdy);
    end
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) exp_q[k].delete();
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (bus.out_ready[k] && exp_q[k].size() != 0) begin
          void'(exp_q[k].pop_front());
          pop_cnt[k]++;
        end
      end
      if (bus.in_valid && exp_rdy) exp_q[bus.in_sel].push_back(bus.in_data);
    end
  endtask

  // One clock: scoreboard at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (mon_en) sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [W-1:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_sel   = chan_sel_t'(ch);
    bus.in_data  = d;
    #1;
    while (!bus.in_ready && n < 20) begin
      cycle();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ch%0d data %h", ch, d);
    end
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = '1;
    while (bus.out_valid != '0 && n < 40) begin
      cycle();
      n++;
    end
    if (bus.out_valid != '0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout out_valid %b", bus.out_valid);
    end
    bus.out_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd2;
    bus.in_data   = 4'hF;
    bus.out_ready = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready got %b exp 0", bus.in_ready);
      end
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    mon_en = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.out_level !== 8'h00 || bus.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state valid %b level %h data %h exp 0/00/0000",
               bus.out_valid, bus.out_level, bus.out_data);
    end
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd2;
    bus.in_data  = 4'hA;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_accept in_ready got %b exp 1", bus.in_ready);
    end
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 4'b0100 || bus.out_data[2] !== 4'hA || bus.out_level[2] !== 2'd1) begin
      errors++;
      $display("FAIL single_word valid %b data2 %h level2 %0d exp 0100/a/1",
               bus.out_valid, bus.out_data[2], bus.out_level[2]);
    end
    drain();
  endtask

  task automatic test_fill_backpressure();
    bus.out_ready = '0;
    send(1, 4'h1);
    send(1, 4'h2);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd1;
    bus.in_data  = 4'h3;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_level[1] !== 2'd2) begin
      errors++;
      $display("FAIL fill_full in_ready %b level1 %0d exp 0/2", bus.in_ready, bus.out_level[1]);
    end
    bus.out_ready[1] = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_no_comb_path in_ready got %b exp 0", bus.in_ready);
    end
    cycle();
    bus.out_ready[1] = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_data[1] !== 4'h2 || bus.out_level[1] !== 2'd1) begin
      errors++;
      $display("FAIL fill_after_pop in_ready %b data1 %h level1 %0d exp 1/2/1",
               bus.in_ready, bus.out_data[1], bus.out_level[1]);
    end
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_level[1] !== 2'd2 || bus.out_data[1] !== 4'h2) begin
      errors++;
      $display("FAIL fill_refill level1 %0d data1 %h exp 2/2", bus.out_level[1], bus.out_data[1]);
    end
    drain();
  endtask

  task automatic test_isolation();
    logic [W-1:0] d;
    logic [W-1:0] prev;
    bus.out_ready = '0;
    send(0, 4'h7);
    send(0, 4'h8);
    bus.out_ready = 4'b1000;
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      d = W'(i * 3 + 1);
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd3;
      bus.in_data  = d;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL iso_accept word %0d in_ready got %b exp 1", i, bus.in_ready);
      end
      if (i > 0) begin
        checks++;
        if (bus.out_valid[3] !== 1'b1 || bus.out_level[3] !== 2'd1 || bus.out_data[3] !== prev) begin
          errors++;
          $display("FAIL iso_rate word %0d valid3 %b level3 %0d data3 %h exp 1/1/%h",
                   i, bus.out_valid[3], bus.out_level[3], bus.out_data[3], prev);
        end
      end
      prev = d;
      cycle();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_level[3] !== 2'd1 || bus.out_data[3] !== prev ||
        bus.out_level[0] !== 2'd2 || bus.out_data[0] !== 4'h7) begin
      errors++;
      $display("FAIL iso_final level3 %0d data3 %h level0 %0d data0 %h exp 1/%h/2/7",
               bus.out_level[3], bus.out_data[3], bus.out_level[0], bus.out_data[0], prev);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    bus.out_ready = '0;
    send(2, 4'h9);
    bus.in_valid     = 1'b1;
    bus.in_sel       = 2'd2;
    bus.in_data      = 4'h5;
    bus.out_ready[2] = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_data[2] !== 4'h9 || bus.out_level[2] !== 2'd1) begin
      errors++;
      $display("FAIL simul_pre in_ready %b data2 %h level2 %0d exp 1/9/1",
               bus.in_ready, bus.out_data[2], bus.out_level[2]);
    end
    cycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    checks++;
    if (bus.out_level[2] !== 2'd1 || bus.out_data[2] !== 4'h5) begin
      errors++;
      $display("FAIL simul_post level2 %0d data2 %h exp 1/5", bus.out_level[2], bus.out_data[2]);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int base [N_OUT];
    for (int k = 0; k < N_OUT; k++) base[k] = pop_cnt[k];
    bus.out_ready = '1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = chan_sel_t'(i % 4);
      bus.in_data  = W'(15 - i);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rr_accept word %0d in_ready got %b exp 1", i, bus.in_ready);
      end
      cycle();
    end
    bus.in_valid = 1'b0;
    drain();
    for (int k = 0; k < N_OUT; k++) begin
      checks++;
      if (pop_cnt[k] - base[k] != 4) begin
        errors++;
        $display("FAIL rr_count ch%0d got %0d exp 4", k, pop_cnt[k] - base[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = '0;
    send(0, 4'h1);
    send(0, 4'h2);
    send(1, 4'h3);
    send(3, 4'h4);
    send(3, 4'h5);
    checks++;
    if (bus.out_level !== 8'h86) begin
      errors++;
      $display("FAIL mid_levels got %h exp 86", bus.out_level);
    end
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd2;
    bus.in_data  = 4'hF;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_ready got %b exp 0", bus.in_ready);
    end
    cycle();
    rst_n = 1'b1;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.out_level !== 8'h00 || bus.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid_cleared valid %b level %h data %h exp 0/00/0000",
               bus.out_valid, bus.out_level, bus.out_data);
    end
    bus.in_sel  = 2'd1;
    bus.in_data = 4'hC;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_first_accept in_ready got %b exp 1", bus.in_ready);
    end
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 4'b0010 || bus.out_data[1] !== 4'hC) begin
      errors++;
      $display("FAIL mid_after valid %b data1 %h exp 0010/c", bus.out_valid, bus.out_data[1]);
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    for (int k = 0; k < N_OUT; k++) pop_cnt[k] = 0;
    test_reset();
    test_fill_backpressure();
    test_isolation();
    test_simultaneous();
    test_round_robin();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
